// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath/memory.
// Handshake: a memory state holds its strobes until a cycle with mem_ready=1, which completes that access.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, instr_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: registered state machine with memory wait states,
// optional addi, illegal-opcode flag and a retired-instruction counter.
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT    = 1,
    parameter int unsigned ENABLE_ADDI = 1,
    parameter int          CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit WAIT_EN = (MEM_WAIT != 0);
    localparam bit ADDI_EN = (ENABLE_ADDI != 0);

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic       mem_go;
    logic       dec_illegal;
    logic       done;
    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       mem_to_reg_c;
    logic       reg_dst_c;
    logic       reg_write_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_source_c;

    // Without wait states every memory access is taken to finish in one cycle.
    assign mem_go = bus.mem_ready | ~WAIT_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= dec_illegal;
            if (done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        dec_illegal     = 1'b0;
        done            = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_dst_c       = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                // IR/PC load only on the completing cycle, so a stall never double-increments PC.
                if (mem_go) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            state_d = S_ADDI_EX;
                        end else begin
                            state_d     = S_FETCH;
                            dec_illegal = 1'b1;
                        end
                    end
                    default: begin
                        state_d     = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_go) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                done         = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_go) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = S_RWB;
            end
            S_RWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                done        = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
                done            = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                done        = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                done        = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write/load strobes are held off while reset is asserted, even though FETCH decodes them.
    assign bus.pc_write      = pc_write_c & rst_n;
    assign bus.pc_write_cond = pc_write_cond_c & rst_n;
    assign bus.ir_write      = ir_write_c & rst_n;
    assign bus.reg_write     = reg_write_c & rst_n;
    assign bus.mem_read      = mem_read_c & rst_n;
    assign bus.mem_write     = mem_write_c & rst_n;

    assign bus.i_or_d      = i_or_d_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.reg_dst     = reg_dst_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.pc_source   = pc_source_c;
    assign bus.state       = state_q;
    assign bus.instr_done  = done;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: one wait-state/addi/4-bit-counter instance and one
// single-cycle-memory/no-addi instance, checked cycle by cycle against an instruction-level model.
module tb_mc_control_fsm;
  localparam int W = 54;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic clk;
  logic rst_n;
  int n_checks;
  int n_errors;
  bit mon_a;
  bit mon_b;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [31:0] cnt_m[2];
  bit ill_m[2];
  logic [W-1:0] obs_a;
  logic [W-1:0] obs_b;

  mc_control_fsm_if #(.CNT_W(4))  bus_a();
  mc_control_fsm_if #(.CNT_W(32)) bus_b();

  mc_control_fsm #(.MEM_WAIT(1), .ENABLE_ADDI(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mc_control_fsm #(.MEM_WAIT(0), .ENABLE_ADDI(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  assign obs_a = {bus_a.state, bus_a.pc_write, bus_a.pc_write_cond, bus_a.i_or_d, bus_a.mem_read,
                  bus_a.mem_write, bus_a.ir_write, bus_a.mem_to_reg, bus_a.reg_dst, bus_a.reg_write,
                  bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source,
                  bus_a.instr_done, bus_a.illegal_op, 28'd0, bus_a.instr_count};
  assign obs_b = {bus_b.state, bus_b.pc_write, bus_b.pc_write_cond, bus_b.i_or_d, bus_b.mem_read,
                  bus_b.mem_write, bus_b.ir_write, bus_b.mem_to_reg, bus_b.reg_dst, bus_b.reg_write,
                  bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op, bus_b.pc_source,
                  bus_b.instr_done, bus_b.illegal_op, bus_b.instr_count};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control word for one cycle, taken from the per-state output table.
  function automatic logic [W-1:0] model_rec(input logic [3:0] st, input bit go, input bit done,
                                             input bit ill, input logic [31:0] cnt);
    logic pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, ps;
    pcw = 0; pcc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; sa = 0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = go; pcw = go; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; end
      4'd9:  begin pcw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {st, pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, done, ill, cnt};
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: one clock cycle of stimulus plus its expected response
  task automatic step(input int d, input logic [5:0] op, input logic [3:0] st,
                      input bit rdy, input bit retire);
    bit go;
    go = rdy || (d == 1);
    if (d == 0) begin
      bus_a.opcode = op;
      bus_a.mem_ready = rdy;
      exp_q_a.push_back(model_rec(st, go, retire, ill_m[0], cnt_m[0]));
    end else begin
      bus_b.opcode = op;
      bus_b.mem_ready = rdy;
      exp_q_b.push_back(model_rec(st, go, retire, ill_m[1], cnt_m[1]));
    end
    ill_m[d] = 0;
    if (retire) cnt_m[d] = (d == 0) ? ((cnt_m[d] + 1) & 32'hF) : (cnt_m[d] + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input int d, input logic [5:0] op, input logic [3:0] st,
                           input int stalls, input bit retire_on_go);
    int k;
    bit rdy;
    bit go;
    k = 0;
    forever begin
      if (d == 0) rdy = (k >= stalls);
      else rdy = rnd_bit();
      go = rdy || (d == 1);
      step(d, op, st, rdy, retire_on_go && go);
      k++;
      if (go) break;
    end
  endtask

  task automatic run_instr(input int d, input logic [5:0] op, input int fst, input int mst);
    mem_phase(d, op, 4'd0, fst, 1'b0);
    step(d, op, 4'd1, rnd_bit(), 1'b0);
    if (op == OP_LW) begin
      step(d, op, 4'd2, rnd_bit(), 1'b0);
      mem_phase(d, op, 4'd3, mst, 1'b0);
      step(d, op, 4'd4, rnd_bit(), 1'b1);
    end else if (op == OP_SW) begin
      step(d, op, 4'd2, rnd_bit(), 1'b0);
      mem_phase(d, op, 4'd5, mst, 1'b1);
    end else if (op == OP_R) begin
      step(d, op, 4'd6, rnd_bit(), 1'b0);
      step(d, op, 4'd7, rnd_bit(), 1'b1);
    end else if (op == OP_BEQ) begin
      step(d, op, 4'd8, rnd_bit(), 1'b1);
    end else if (op == OP_J) begin
      step(d, op, 4'd9, rnd_bit(), 1'b1);
    end else if (op == OP_ADDI && d == 0) begin
      step(d, op, 4'd10, rnd_bit(), 1'b0);
      step(d, op, 4'd11, rnd_bit(), 1'b1);
    end else begin
      ill_m[d] = 1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: one expected record per monitored DUT per cycle
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_a) begin
        if (exp_q_a.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mon_a: got %h with empty expected queue at %0t", obs_a, $time);
        end else begin
          e = exp_q_a.pop_front();
          n_checks++;
          if (obs_a !== e) begin
            n_errors++;
            $display("FAIL mon_a: got %h expected %h at %0t", obs_a, e, $time);
          end
        end
      end
      if (mon_b) begin
        if (exp_q_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mon_b: got %h with empty expected queue at %0t", obs_b, $time);
        end else begin
          e = exp_q_b.pop_front();
          n_checks++;
          if (obs_b !== e) begin
            n_errors++;
            $display("FAIL mon_b: got %h expected %h at %0t", obs_b, e, $time);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    mon_a = 0;
    mon_b = 0;
    exp_q_a.delete();
    exp_q_b.delete();
    rst_n = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    ill_m[0] = 0; ill_m[1] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_a = 0;
    mon_b = 0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    ill_m[0] = 0; ill_m[1] = 0;
    bus_a.opcode = OP_R; bus_a.mem_ready = 1'b1;
    bus_b.opcode = OP_R; bus_b.mem_ready = 1'b1;
    rst_n = 1'b0;
    fork
      monitor();
    join_none

    // reset values with mem_ready high, so FETCH strobes would otherwise fire
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_state", 64'(bus_a.state), 64'd0);
    chk("rst_a_count", 64'(bus_a.instr_count), 64'd0);
    chk("rst_a_illegal", 64'(bus_a.illegal_op), 64'd0);
    chk("rst_a_done", 64'(bus_a.instr_done), 64'd0);
    chk("rst_a_strobes", 64'({bus_a.pc_write, bus_a.ir_write, bus_a.mem_read, bus_a.mem_write,
                              bus_a.reg_write, bus_a.pc_write_cond}), 64'd0);
    chk("rst_b_state", 64'(bus_b.state), 64'd0);
    chk("rst_b_count", 64'(bus_b.instr_count), 64'd0);
    chk("rst_b_strobes", 64'({bus_b.pc_write, bus_b.ir_write, bus_b.mem_read, bus_b.mem_write,
                              bus_b.reg_write, bus_b.pc_write_cond}), 64'd0);

    // wait-state instance: directed scenarios then random traffic
    do_reset();
    mon_a = 1;
    run_instr(0, OP_R, 0, 0);
    chk("a_count_after_r", 64'(bus_a.instr_count), 64'd1);
    run_instr(0, OP_LW, 2, 2);
    run_instr(0, OP_SW, 0, 0);
    run_instr(0, OP_BEQ, 0, 0);
    run_instr(0, OP_J, 1, 0);
    chk("a_count_after_j", 64'(bus_a.instr_count), 64'd5);
    run_instr(0, 6'b111111, 0, 0);
    run_instr(0, OP_ADDI, 0, 0);
    run_instr(0, OP_SW, 1, 3);
    for (int i = 0; i < 40; i++) begin
      run_instr(0, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // counter wrap with a 4-bit counter
    do_reset();
    mon_a = 1;
    for (int i = 0; i < 16; i++) run_instr(0, OP_R, 0, 0);
    chk("a_count_wrap", 64'(bus_a.instr_count), 64'd0);

    // asynchronous reset while MEMRD is stalled
    run_instr(0, OP_BEQ, 0, 0);
    step(0, OP_LW, 4'd0, 1'b1, 1'b0);
    step(0, OP_LW, 4'd1, 1'b1, 1'b0);
    step(0, OP_LW, 4'd2, 1'b1, 1'b0);
    step(0, OP_LW, 4'd3, 1'b0, 1'b0);
    mon_a = 0;
    chk("a_pre_reset_state", 64'(bus_a.state), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_midrst_state", 64'(bus_a.state), 64'd0);
    chk("a_midrst_count", 64'(bus_a.instr_count), 64'd0);
    chk("a_midrst_strobes", 64'({bus_a.mem_read, bus_a.mem_write, bus_a.reg_write,
                                 bus_a.pc_write, bus_a.ir_write}), 64'd0);
    do_reset();
    mon_a = 1;
    run_instr(0, OP_R, 1, 0);
    run_instr(0, OP_LW, 0, 1);
    mon_a = 0;

    // single-cycle memory instance without addi
    do_reset();
    mon_b = 1;
    run_instr(1, OP_R, 0, 0);
    run_instr(1, OP_ADDI, 0, 0);
    run_instr(1, OP_LW, 2, 2);
    run_instr(1, 6'b111111, 0, 0);
    run_instr(1, OP_SW, 0, 0);
    chk("b_count_directed", 64'(bus_b.instr_count), 64'd3);
    for (int i = 0; i < 30; i++) begin
      run_instr(1, pick_op(), 0, 0);
    end
    step(1, OP_R, 4'd0, 1'b0, 1'b0);
    mon_b = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle main control unit for the 32-bit MIPS multicycle datapath.
- Replaces the opcode-only control block with an explicit registered state machine. It adds memory wait-state handshaking, optional addi support, illegal-opcode flagging and a retired-instruction counter.
- Drives every datapath control strobe (PC, IR, register file, memory, ALU muxes) from state plus the IR opcode field.

Parameters:
- MEM_WAIT, 1, 1: memory states hold until mem_ready=1. 0: mem_ready is ignored and memory is treated as single-cycle.
- ENABLE_ADDI, 1, 1: opcode 001000 is decoded as addi. 0: it is treated as illegal.
- CNT_W, 32, width of instr_count.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- opcode, input, 6, IR[31:26].
- mem_ready, input, 1, memory access completes this cycle.
- pc_write, output, 1, unconditional PC load.
- pc_write_cond, output, 1, PC load qualified by ALU zero.
- i_or_d, output, 1, memory address select: 0 = PC, 1 = ALU.
- mem_read, output, 1, memory read strobe.
- mem_write, output, 1, memory write strobe.
- ir_write, output, 1, IR load.
- mem_to_reg, output, 1, register write data select: 0 = ALUout, 1 = MDR.
- reg_dst, output, 1, destination register select: 0 = rt, 1 = rd.
- reg_write, output, 1, register file write.
- alu_src_a, output, 1, ALU A select: 0 = PC, 1 = A.
- alu_src_b, output, 2, ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op, output, 2, ALU op: 00 = add, 01 = sub, 10 = funct.
- pc_source, output, 2, next-PC select: 00 = ALU, 01 = ALUout, 10 = jump.
- state, output, 4, current state code.
- instr_done, output, 1, instruction retires this cycle.
- illegal_op, output, 1, one-cycle pulse after an unknown opcode.
- instr_count, output, CNT_W, count of retired instructions.

Behaviour:
- State register is 4 bits and is reset asynchronously to FETCH(0).
- Outputs not listed for a state are 0.
- All strobes are Moore outputs decoded from state, gated by mem_ready where stated.

States and outputs:
- FETCH(0)
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are 1 only when (mem_ready | !MEM_WAIT); this prevents a double PC increment during stalls.
  - Advances to DECODE on the same condition, otherwise holds.
- DECODE(1)
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 001000 -> ADDI_EX if ENABLE_ADDI.
    - Any other opcode -> FETCH and sets illegal_op.
- MEMADR(2)
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw -> MEMRD; sw -> MEMWR.
- MEMRD(3)
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until ready, then -> MEMWB.
- MEMWB(4)
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1.
  - Next state: FETCH.
- MEMWR(5)
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until ready, then -> FETCH.
  - mem_write stays high during the stall.
- EXEC(6)
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: RWB(7).
- RWB(7)
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next state: FETCH.
- BRANCH(8)
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - Next state: FETCH.
- JUMP(9)
  - Outputs: pc_write=1, pc_source=10.
  - Next state: FETCH.
- ADDI_EX(10)
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: ADDI_WB(11).
- ADDI_WB(11)
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
- Codes 12-15 are unreachable; if entered, next state is FETCH and all outputs are 0.

Retirement and counter:
- instr_done=1 in the cycle a terminal state transitions to FETCH.
- Terminal states: MEMWB, MEMWR (only when ready), RWB, BRANCH, JUMP, ADDI_WB.
- instr_count increments by 1 on each instr_done and wraps modulo 2^CNT_W.
- An illegal opcode does not retire and does not count.

illegal_op:
- Registered flag, high for exactly one cycle, coincident with the FETCH cycle that follows the offending DECODE.

Opcode sampling:
- opcode is sampled only in DECODE and MEMADR.
- It is required stable from the IR load until the next FETCH.

Latency (MEM_WAIT=0):
- lw 5 cycles.
- sw, R-type, addi 4 cycles.
- beq, j 3 cycles.
- Each stalled memory cycle adds 1.

Reset:
- Reset values while rst_n=0: state=0, instr_count=0, illegal_op=0, instr_done=0.
- pc_write, pc_write_cond, ir_write, reg_write, mem_read and mem_write are forced to 0 while rst_n is low, including the FETCH-decoded strobes.
- Deasserting rst_n mid-instruction restarts at FETCH; no partial write is issued.
- mem_ready during reset is ignored.

Test Plan:
- Reset then release, MEM_WAIT=0, opcode=000000 -> states 0,1,6,7,0. reg_dst=1 and reg_write=1 in state 7; instr_done pulses once; instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in both FETCH and MEMRD -> FETCH lasts 3 cycles; pc_write and ir_write high only in the 3rd. MEMRD lasts 3 cycles; MEMWB has mem_to_reg=1. Total 9 cycles.
- sw (101011), MEM_WAIT=1, mem_ready=1 -> states 0,1,2,5,0. mem_write=1 and i_or_d=1 only in state 5; reg_write is never 1.
- beq (000100) then j (000010) -> state 8 shows pc_write_cond=1, pc_source=01, alu_op=01. State 9 shows pc_write=1, pc_source=10. instr_count increases by 2.
- opcode 111111, then 001000 with ENABLE_ADDI=0 -> each returns to FETCH after DECODE with a single-cycle illegal_op; instr_count is unchanged. With ENABLE_ADDI=1, 001000 runs 0,1,10,11,0.
- rst_n pulsed low during MEMRD, and CNT_W=4 with 16 retirements -> state returns to 0 asynchronously with no write strobe. The counter reads 0 after wrap.
